// File: rtl/divider_controller.sv
// divider_controller: sequencing FSM for the restoring-division datapath.
// Drives ctrlWord through LOAD, then nBit SHIFT/SUB pairs, then a DONE pulse.
// Ports: clk, rst (sync, active-high), start, msbSub, msbCtr, bZero in;
//        ctrlWord[14:0], busy, done, divErr out.
// Optional feature: define DIV_ZERO_DETECT_EN to send B==0 straight to DONE
// with a divErr pulse; otherwise bZero is ignored and divErr is always 0.
module divider_controller #(
   parameter int nBit = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        msbSub,
   input  logic        msbCtr,
   input  logic        bZero,
   output logic [14:0] ctrlWord,
   output logic        busy,
   output logic        done,
   output logic        divErr
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      SUB   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Control words per state (bit map: A 0-2, B 3-4, R 5-7, Q 8-11, Ctr 12-14)
   localparam logic [14:0] CW_LOAD  = 15'h1134; // A ld, B ld, R/Q/Ctr clr
   localparam logic [14:0] CW_SHIFT = 15'h2042; // A sl, R sl, Ctr sl
   localparam logic [14:0] CW_SUB   = 15'h0200; // Q sl
   localparam logic [14:0] CW_KEEP  = 15'h0880; // R load, Q shiftIn

   state_t      state;
   state_t      state_d;
   logic [14:0] ctrl_q;
   logic [14:0] ctrl_d;
   logic        busy_d;
   logic        done_d;
   logic        err_d;
   logic        err_q;
   logic        zero_req;
   logic        unused_ok;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_req  = bZero;
   assign unused_ok = ^{1'b0, 32'(nBit)};
`else
   assign zero_req  = 1'b0;
   assign unused_ok = ^{bZero, 32'(nBit)};
`endif

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ctrl_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_d;
         ctrl_q <= ctrl_d;
         busy   <= busy_d;
         done   <= done_d;
         err_q  <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = IDLE;
      case (state)
         IDLE: begin
            if (start)
               state_d = zero_req ? DONE : LOAD;
            else
               state_d = IDLE;
         end
         LOAD:    state_d = SHIFT;
         SHIFT:   state_d = SUB;
         SUB:     state_d = msbCtr ? DONE : SHIFT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state, so outputs are registered with it
   always_comb begin
      ctrl_d = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
      case (state_d)
         LOAD:  ctrl_d = CW_LOAD;
         SHIFT: ctrl_d = CW_SHIFT;
         SUB:   ctrl_d = CW_SUB;
         DONE: begin
            done_d = 1'b1;
            err_d  = zero_req && (state == IDLE);
         end
         default: busy_d = 1'b0;
      endcase
   end

   // The subtract/restore choice depends on R-B after the SHIFT edge, which
   // only exists during SUB itself, so those two bits follow msbSub directly.
   assign ctrlWord = ctrl_q |
                     (((state == SUB) && !msbSub) ? CW_KEEP : 15'h0000);
   assign divErr   = err_q;

endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller: directed bench for divider_controller, with a
// behavioural restoring-division datapath model driven by ctrlWord.
module tb_divider_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        bZero;
   logic        msbSub;
   logic        msbCtr;
   logic [14:0] ctrlWord;
   logic        busy;
   logic        done;
   logic        divErr;

   logic [7:0] a_in = 8'd0;
   logic [7:0] b_in = 8'd1;
   logic [7:0] ra = 8'd0;
   logic [7:0] rb = 8'd0;
   logic [7:0] rr = 8'd0;
   logic [7:0] rq = 8'd0;
   logic [7:0] rc = 8'd0;
   logic [7:0] diff;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   divider_controller #(.nBit(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .msbSub   (msbSub),
      .msbCtr   (msbCtr),
      .bZero    (bZero),
      .ctrlWord (ctrlWord),
      .busy     (busy),
      .done     (done),
      .divErr   (divErr)
   );

   assign diff   = rr - rb;
   assign msbSub = diff[7];
   assign msbCtr = rc[7];
   assign bZero  = (b_in == 8'd0);

   // Datapath model
   always @(posedge clk) begin
      if (ctrlWord[0]) ra <= 8'd0;
      else if (ctrlWord[2]) ra <= a_in;
      else if (ctrlWord[1]) ra <= {ra[6:0], 1'b0};
      if (ctrlWord[3]) rb <= 8'd0;
      else if (ctrlWord[4]) rb <= b_in;
      if (ctrlWord[5]) rr <= 8'd0;
      else if (ctrlWord[7]) rr <= diff;
      else if (ctrlWord[6]) rr <= {rr[6:0], ra[7]};
      if (ctrlWord[8]) rq <= 8'd0;
      else if (ctrlWord[9]) rq <= {rq[6:0], ctrlWord[11]};
      if (ctrlWord[12]) rc <= 8'd0;
      else if (ctrlWord[13]) rc <= {rc[6:0], 1'b1};
   end

   // Stimulus helper: one division, returns observations only.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          input int pa, input int pb,
                          output int dcyc, output int busy_bad,
                          output int restores, output logic [7:0] q,
                          output logic [7:0] r, output logic err,
                          output logic [14:0] cw1, output logic [14:0] cw2,
                          output int extra);
      a_in = a;
      b_in = b;
      dcyc = -1;
      busy_bad = 0;
      restores = 0;
      extra = 0;
      q = 8'd0;
      r = 8'd0;
      err = 1'b0;
      cw1 = '0;
      cw2 = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 100 && dcyc < 0; c++) begin
         @(negedge clk);
         start = (c == pa) || (c == pb);
         if (c == 1) cw1 = ctrlWord;
         if (c == 2) cw2 = ctrlWord;
         if (busy !== 1'b1) busy_bad++;
         if (ctrlWord[9] && !ctrlWord[7]) restores++;
         if (done === 1'b1) begin
            dcyc = c;
            q = rq;
            r = rr;
            err = divErr;
         end
      end
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ctrlWord !== 15'h0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%h exp=0000", ctrlWord);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", done);
      end
      checks++;
      if (divErr !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b exp=0", divErr);
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int dc, bb, rs, ex;
      logic [7:0] q, r;
      logic e;
      logic [14:0] c1, c2;
      run_div(8'd100, 8'd7, 0, 0, dc, bb, rs, q, r, e, c1, c2, ex);
      checks++;
      if (dc !== 18) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=18", dc);
      end
      checks++;
      if (q !== 8'd14 || r !== 8'd2) begin
         failures++;
         $display("FAIL basic_qr got=%0d/%0d exp=14/2", q, r);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL basic_busy lowcycles=%0d exp=0", bb);
      end
      checks++;
      if (c1 !== 15'h1134) begin
         failures++;
         $display("FAIL basic_load_cw got=%h exp=1134", c1);
      end
      checks++;
      if (c2 !== 15'h2042) begin
         failures++;
         $display("FAIL basic_shift_cw got=%h exp=2042", c2);
      end
      checks++;
      if (e !== 1'b0 || ex !== 0) begin
         failures++;
         $display("FAIL basic_tail err=%b stray=%0d exp=0/0", e, ex);
      end
   endtask

   task automatic test_small_dividend;
      int dc, bb, rs, ex;
      logic [7:0] q, r;
      logic e;
      logic [14:0] c1, c2;
      run_div(8'd5, 8'd9, 0, 0, dc, bb, rs, q, r, e, c1, c2, ex);
      checks++;
      if (q !== 8'd0 || r !== 8'd5) begin
         failures++;
         $display("FAIL small_5_9 got=%0d/%0d exp=0/5", q, r);
      end
      checks++;
      if (rs !== 8) begin
         failures++;
         $display("FAIL small_restores got=%0d exp=8", rs);
      end
      run_div(8'd0, 8'd3, 0, 0, dc, bb, rs, q, r, e, c1, c2, ex);
      checks++;
      if (q !== 8'd0 || r !== 8'd0 || dc !== 18) begin
         failures++;
         $display("FAIL small_0_3 got=%0d/%0d@%0d exp=0/0@18", q, r, dc);
      end
   endtask

   task automatic test_back_to_back;
      int d1, d2;
      logic [7:0] q1, r1, q2, r2;
      d1 = -1;
      d2 = -1;
      q1 = 0; r1 = 0; q2 = 0; r2 = 0;
      a_in = 8'd42;
      b_in = 8'd6;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 120 && d2 < 0; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (d1 < 0) begin
               d1 = c;
               q1 = rq;
               r1 = rr;
               a_in = 8'd127;
               b_in = 8'd127;
            end else begin
               d2 = c;
               q2 = rq;
               r2 = rr;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (d1 !== 18 || q1 !== 8'd7 || r1 !== 8'd0) begin
         failures++;
         $display("FAIL b2b_first got=%0d/%0d@%0d exp=7/0@18", q1, r1, d1);
      end
      checks++;
      if (d2 !== 37) begin
         failures++;
         $display("FAIL b2b_second_time got=%0d exp=37", d2);
      end
      checks++;
      if (q2 !== 8'd1 || r2 !== 8'd0) begin
         failures++;
         $display("FAIL b2b_second_qr got=%0d/%0d exp=1/0", q2, r2);
      end
   endtask

   task automatic test_start_busy;
      int dc, bb, rs, ex;
      logic [7:0] q, r;
      logic e;
      logic [14:0] c1, c2;
      run_div(8'd77, 8'd5, 3, 10, dc, bb, rs, q, r, e, c1, c2, ex);
      checks++;
      if (dc !== 18) begin
         failures++;
         $display("FAIL busy_start_latency got=%0d exp=18", dc);
      end
      checks++;
      if (q !== 8'd15 || r !== 8'd2) begin
         failures++;
         $display("FAIL busy_start_qr got=%0d/%0d exp=15/2", q, r);
      end
      checks++;
      if (ex !== 0) begin
         failures++;
         $display("FAIL busy_start_restart stray=%0d exp=0", ex);
      end
   endtask

   task automatic test_reset_mid;
      int stray, dc, bb, rs, ex;
      logic [7:0] q, r;
      logic e;
      logic [14:0] c1, c2;
      stray = 0;
      a_in = 8'd99;
      b_in = 8'd4;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 7) rst = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (ctrlWord !== 15'h0000 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs got=%h/%b/%b exp=0000/0/0",
                  ctrlWord, busy, done);
      end
      rst = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL midrst_idle stray=%0d exp=0", stray);
      end
      run_div(8'd99, 8'd4, 0, 0, dc, bb, rs, q, r, e, c1, c2, ex);
      checks++;
      if (q !== 8'd24 || r !== 8'd3 || dc !== 18) begin
         failures++;
         $display("FAIL midrst_rerun got=%0d/%0d@%0d exp=24/3@18", q, r, dc);
      end
   endtask

   task automatic test_div_zero;
      int dc, bb, rs, ex;
      logic [7:0] q, r, pq, pr;
      logic e;
      logic [14:0] c1, c2;
      pq = rq;
      pr = rr;
      run_div(8'd50, 8'd0, 0, 0, dc, bb, rs, q, r, e, c1, c2, ex);
`ifdef DIV_ZERO_DETECT_EN
      checks++;
      if (dc !== 1 || e !== 1'b1) begin
         failures++;
         $display("FAIL zero_detect got=@%0d err=%b exp=@1 err=1", dc, e);
      end
      checks++;
      if (c1 !== 15'h0000 || q !== pq || r !== pr) begin
         failures++;
         $display("FAIL zero_hold cw=%h qr=%0d/%0d exp=0000 %0d/%0d",
                  c1, q, r, pq, pr);
      end
`else
      checks++;
      if (dc !== 18 || e !== 1'b0) begin
         failures++;
         $display("FAIL zero_full got=@%0d err=%b exp=@18 err=0", dc, e);
      end
      checks++;
      if (q !== 8'd255 || r !== 8'd50 || pq === 8'hxx || pr === 8'hxx) begin
         failures++;
         $display("FAIL zero_qr got=%0d/%0d exp=255/50", q, r);
      end
`endif
      checks++;
      if (ex !== 0) begin
         failures++;
         $display("FAIL zero_tail stray=%0d exp=0", ex);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_small_dividend();
      test_back_to_back();
      test_start_busy();
      test_reset_mid();
      test_div_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
